// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first ripple adder with valid/ready request and result handshakes.
// Define SERIAL_ADDER_SUB_EN to add the sub input (sum_out = a_in - b_in, cout = no borrow).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             s_d, c_d, c0_d;
    logic [WIDTH:0]   sh_d;
    logic [WIDTH-1:0] b_d;
    always_comb begin
        s_d  = a_q[0] ^ b_q[0] ^ carry_q;
        c_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        sh_d = {s_d, sum_q};
`ifdef SERIAL_ADDER_SUB_EN
        b_d  = sub ? ~b_in : b_in;
        c0_d = sub | cin;
`else
        b_d  = b_in;
        c0_d = cin;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_valid) begin
                    a_q     <= a_in;
                    b_q     <= b_d;
                    carry_q <= c0_d;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    // sum fills from the MSB so bit 0 lands at the bottom after WIDTH shifts
                    sum_q   <= sh_d[WIDTH:1];
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= c_d;
                    cout_q  <= c_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
                end
                DONE: if (done_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign start_ready = (state_q == IDLE);
    assign done_valid  = (state_q == DONE);
    assign sum_out     = sum_q;
    assign cout        = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks 8-bit and 3-bit serial_adder instances against plain integer arithmetic.
module tb_serial_adder;
    logic       clk = 1'b0, rst = 1'b1;
    logic       sv8 = 0, dr8 = 0, cin8 = 0, sub8 = 0, sr8, co8, dv8;
    logic [7:0] a8 = 0, b8 = 0, so8;
    logic       sv3 = 0, dr3 = 0, cin3 = 0, sub3 = 0, sr3, co3, dv3;
    logic [2:0] a3 = 0, b3 = 0, so3;
    int         n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .a_in(a8), .b_in(b8), .cin(cin8), .sum_out(so8), .cout(co8),
        .done_valid(dv8), .done_ready(dr8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(sr3),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub3),
`endif
        .a_in(a3), .b_in(b3), .cin(cin3), .sum_out(so3), .cout(co3),
        .done_valid(dv3), .done_ready(dr3)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sr8, dv8, co8, so8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset8: ready/valid/cout/sum = %b/%b/%b/%h, want 1/0/0/00", sr8, dv8, co8, so8);
        end
        n_checks++;
        if ({sr3, dv3, co3, so3} !== {1'b1, 1'b0, 1'b0, 3'h0}) begin
            n_fail++;
            $display("FAIL reset3: ready/valid/cout/sum = %b/%b/%b/%h, want 1/0/0/0", sr3, dv3, co3, so3);
        end
        rst = 1'b0;
    endtask

    // One full transaction on the 8-bit instance; inputs are scrambled right after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s, input string tag);
        logic [8:0] exp;
        int n;
        exp = s ? {(a >= b), 8'(a - b)} : 9'(a) + 9'(b) + 9'(c);
        a8 = a; b8 = b; cin8 = c; sub8 = s; sv8 = 1'b1;
        @(posedge clk);
        #1;
        sv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!dv8 && n < 20);
        n_checks++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, want 8", tag, n);
        end
        n_checks++;
        if ({co8, so8} !== exp) begin
            n_fail++;
            $display("FAIL %s result: got cout=%b sum=%h, want cout=%b sum=%h", tag, co8, so8, exp[8], exp[7:0]);
        end
        dr8 = 1'b1;
        @(posedge clk);
        #1;
        dr8 = 1'b0;
        n_checks++;
        if (sr8 !== 1'b1 || dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: ready=%b valid=%b, want 1/0", tag, sr8, dv8);
        end
    endtask

    task automatic test_add;
        run8(8'h00, 8'h00, 1'b0, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, 1'b0, "wrap");
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, "a5_5a_c");
        for (int i = 0; i < 20; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rand");
    endtask

    task automatic test_backpressure;
        logic [7:0] a, b, hs;
        logic c, hc;
        int n;
        a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
        a8 = a; b8 = b; cin8 = c; sub8 = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        #1;
        sv8 = 1'b0;
        n = 0;
        while (!dv8 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        hs = so8; hc = co8;
        n_checks++;
        if ({hc, hs} !== 9'(a) + 9'(b) + 9'(c)) begin
            n_fail++;
            $display("FAIL bp result: got %b/%h, want %h", hc, hs, 9'(a) + 9'(b) + 9'(c));
        end
        for (int k = 0; k < 5; k++) begin
            sv8 = (k == 2);
            a8 = ~a; b8 = ~b;
            @(posedge clk);
            #1;
            n_checks++;
            if ({dv8, sr8, co8, so8} !== {1'b1, 1'b0, hc, hs}) begin
                n_fail++;
                $display("FAIL bp hold %0d: valid/ready/cout/sum = %b/%b/%b/%h, want 1/0/%b/%h", k, dv8, sr8, co8, so8, hc, hs);
            end
        end
        sv8 = 1'b0; dr8 = 1'b1;
        @(posedge clk);
        #1;
        dr8 = 1'b0;
        n_checks++;
        if (sr8 !== 1'b1 || dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp release: ready=%b valid=%b, want 1/0", sr8, dv8);
        end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (sr8 !== 1'b1 || dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp queued: ready=%b valid=%b, want 1/0", sr8, dv8);
        end
    endtask

    task automatic test_reset_mid_run;
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; sv8 = 1'b1;
        @(posedge clk);
        #1;
        sv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        n_checks++;
        if ({dv8, sr8, co8, so8} !== {1'b1 == 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst: valid/ready/cout/sum = %b/%b/%b/%h, want 0/1/0/00", dv8, sr8, co8, so8);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst pulse: valid=%b, want 0", dv8);
        end
        run8(8'h12, 8'h34, 1'b0, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back3;
        logic [3:0] exp;
        int n;
        dr3 = 1'b1;
        for (int i = 0; i < 128; i++) begin
            n = 0;
            while (!sr3 && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            a3 = 3'(i); b3 = 3'(i >> 3); cin3 = 1'(i >> 6); sv3 = 1'b1;
            exp = 4'(i & 7) + 4'((i >> 3) & 7) + 4'((i >> 6) & 1);
            @(posedge clk);
            #1;
            sv3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!dv3 && n < 10);
            n_checks++;
            if (n !== 3) begin
                n_fail++;
                $display("FAIL w3 latency %0d: got %0d edges, want 3", i, n);
            end
            n_checks++;
            if ({co3, so3} !== exp) begin
                n_fail++;
                $display("FAIL w3 result %0d: got %b/%h, want %h", i, co3, so3, exp);
            end
        end
        @(posedge clk);
        #1;
        dr3 = 1'b0;
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        run8(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        run8(8'h00, 8'h01, 1'b1, 1'b1, "sub_00_01");
        for (int i = 0; i < 10; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, "sub_rand");
    endtask
`endif

    initial begin
        test_reset;
        test_add;
        test_backpressure;
        test_reset_mid_run;
        test_back_to_back3;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
